// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: parses framed byte packets into register writes,
// streamed framebuffer writes and (with FILL_CMD_EN defined) hardware fill runs.
module spi_cmd_ctrl #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FrameActive,
    input  logic              ByteStrobe,
    input  logic [7:0]        ByteData,
    output logic              RegWe,
    output logic [7:0]        RegAddr,
    output logic [7:0]        RegData,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        MemData,
    input  logic              MemReady,
    output logic              Busy,
    output logic              ErrCmd,
    output logic              Overrun
);
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_REG_A, S_REG_D, S_ADR_H, S_ADR_L, S_STREAM, S_DISCARD
`ifdef FILL_CMD_EN
        , S_CNT_H, S_CNT_L, S_VAL, S_FILL
`endif
    } state_t;

    if (CNT_W < 1 || ADDR_W < 1) begin : g_param_check
        $error("spi_cmd_ctrl: ADDR_W and CNT_W must be positive");
    end

    state_t             state_reg, state_next;
    logic               strobe_d_reg, frame_d_reg;
    logic               reg_we_reg, reg_we_next;
    logic [7:0]         reg_addr_reg, reg_addr_next;
    logic [7:0]         reg_data_reg, reg_data_next;
    logic               mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
    logic [7:0]         mem_data_reg, mem_data_next;
    logic [ADDR_W-1:0]  ptr_reg, ptr_next;
    logic [7:0]         adr_hi_reg, adr_hi_next;
    logic               err_reg, err_next;
    logic               ovr_reg, ovr_next;
    logic               in_fill;
`ifdef FILL_CMD_EN
    logic               fill_sel_reg, fill_sel_next;
    logic [7:0]         cnt_hi_reg, cnt_hi_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [7:0]         fill_val_reg, fill_val_next;
`endif

    logic byte_take, frame_start, frame_end, can_issue;
    logic [15:0] wide_addr;

    assign byte_take   = ByteStrobe && !strobe_d_reg && FrameActive;
    assign frame_start = FrameActive && !frame_d_reg;
    assign frame_end   = !FrameActive && frame_d_reg;
    // A new write may be launched when nothing is pending or the pending one is being accepted now.
    assign can_issue   = !mem_we_reg || MemReady;
    assign wide_addr   = {adr_hi_reg, ByteData};
`ifdef FILL_CMD_EN
    assign in_fill     = (state_reg == S_FILL);
`else
    assign in_fill     = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            strobe_d_reg <= 1'b0;
            frame_d_reg  <= 1'b0;
            reg_we_reg   <= 1'b0;
            reg_addr_reg <= '0;
            reg_data_reg <= '0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            ptr_reg      <= '0;
            adr_hi_reg   <= '0;
            err_reg      <= 1'b0;
            ovr_reg      <= 1'b0;
`ifdef FILL_CMD_EN
            fill_sel_reg <= 1'b0;
            cnt_hi_reg   <= '0;
            cnt_reg      <= '0;
            fill_val_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            strobe_d_reg <= ByteStrobe;
            frame_d_reg  <= FrameActive;
            reg_we_reg   <= reg_we_next;
            reg_addr_reg <= reg_addr_next;
            reg_data_reg <= reg_data_next;
            mem_we_reg   <= mem_we_next;
            mem_addr_reg <= mem_addr_next;
            mem_data_reg <= mem_data_next;
            ptr_reg      <= ptr_next;
            adr_hi_reg   <= adr_hi_next;
            err_reg      <= err_next;
            ovr_reg      <= ovr_next;
`ifdef FILL_CMD_EN
            fill_sel_reg <= fill_sel_next;
            cnt_hi_reg   <= cnt_hi_next;
            cnt_reg      <= cnt_next;
            fill_val_reg <= fill_val_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        reg_we_next   = 1'b0;
        reg_addr_next = reg_addr_reg;
        reg_data_next = reg_data_reg;
        mem_we_next   = mem_we_reg && !MemReady;
        mem_addr_next = mem_addr_reg;
        mem_data_next = mem_data_reg;
        ptr_next      = ptr_reg;
        adr_hi_next   = adr_hi_reg;
        err_next      = err_reg;
        ovr_next      = ovr_reg;
`ifdef FILL_CMD_EN
        fill_sel_next = fill_sel_reg;
        cnt_hi_next   = cnt_hi_reg;
        cnt_next      = cnt_reg;
        fill_val_next = fill_val_reg;
`endif

        if (frame_start) begin
            err_next = 1'b0;
            ovr_next = 1'b0;
            if (state_reg == S_IDLE) state_next = S_CMD;
        end
        if (frame_end && !in_fill) state_next = S_IDLE;

        if (byte_take && state_reg != S_IDLE) begin
            case (state_reg)
                S_CMD: begin
                    case (ByteData)
                        8'h01: state_next = S_REG_A;
                        8'h02: begin
                            state_next = S_ADR_H;
`ifdef FILL_CMD_EN
                            fill_sel_next = 1'b0;
`endif
                        end
`ifdef FILL_CMD_EN
                        8'h03: begin
                            state_next    = S_ADR_H;
                            fill_sel_next = 1'b1;
                        end
`endif
                        default: begin
                            err_next   = 1'b1;
                            state_next = S_DISCARD;
                        end
                    endcase
                end
                S_REG_A: begin
                    reg_addr_next = ByteData;
                    state_next    = S_REG_D;
                end
                S_REG_D: begin
                    reg_we_next   = 1'b1;
                    reg_data_next = ByteData;
                    state_next    = S_CMD;
                end
                S_ADR_H: begin
                    adr_hi_next = ByteData;
                    state_next  = S_ADR_L;
                end
                S_ADR_L: begin
                    ptr_next = ADDR_W'(wide_addr);
`ifdef FILL_CMD_EN
                    state_next = fill_sel_reg ? S_CNT_H : S_STREAM;
`else
                    state_next = S_STREAM;
`endif
                end
                S_STREAM: begin
                    if (can_issue) begin
                        mem_we_next   = 1'b1;
                        mem_addr_next = ptr_reg;
                        mem_data_next = ByteData;
                        ptr_next      = ptr_reg + ADDR_W'(1);
                    end else begin
                        ovr_next = 1'b1;
                    end
                end
`ifdef FILL_CMD_EN
                S_CNT_H: begin
                    cnt_hi_next = ByteData;
                    state_next  = S_CNT_L;
                end
                S_CNT_L: begin
                    cnt_next   = CNT_W'({cnt_hi_reg, ByteData});
                    state_next = S_VAL;
                end
                S_VAL: begin
                    fill_val_next = ByteData;
                    if (cnt_reg == '0) begin
                        state_next = S_CMD;
                    end else begin
                        state_next = S_FILL;
                        if (can_issue) begin
                            mem_we_next   = 1'b1;
                            mem_addr_next = ptr_reg;
                            mem_data_next = ByteData;
                            ptr_next      = ptr_reg + ADDR_W'(1);
                            cnt_next      = cnt_reg - CNT_W'(1);
                        end
                    end
                end
                S_FILL: ovr_next = 1'b1;
`endif
                default: ;
            endcase
        end

`ifdef FILL_CMD_EN
        // cnt_reg counts writes still to be launched; the run ends once the last one is accepted.
        if (state_reg == S_FILL && can_issue) begin
            if (cnt_reg != '0) begin
                mem_we_next   = 1'b1;
                mem_addr_next = ptr_reg;
                mem_data_next = fill_val_reg;
                ptr_next      = ptr_reg + ADDR_W'(1);
                cnt_next      = cnt_reg - CNT_W'(1);
            end else begin
                state_next = FrameActive ? S_CMD : S_IDLE;
            end
        end
`endif
    end

    assign RegWe   = reg_we_reg;
    assign RegAddr = reg_addr_reg;
    assign RegData = reg_data_reg;
    assign MemWe   = mem_we_reg;
    assign MemAddr = mem_addr_reg;
    assign MemData = mem_data_reg;
    assign Busy    = mem_we_reg || in_fill;
    assign ErrCmd  = err_reg;
    assign Overrun = ovr_reg;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: table of framed packets with a write scoreboard,
// plus hand sequences for latency, overrun/backpressure and asynchronous reset.
module tb_spi_cmd_ctrl;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_active;
    logic              byte_strobe;
    logic [7:0]        byte_data;
    logic              mem_ready;
    logic              RegWe;
    logic [7:0]        RegAddr;
    logic [7:0]        RegData;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [7:0]        MemData;
    logic              Busy;
    logic              ErrCmd;
    logic              Overrun;

    logic toggle_en = 1'b0;
    logic tog_bit   = 1'b1;
    logic ready_val = 1'b1;
    assign mem_ready = toggle_en ? tog_bit : ready_val;

    spi_cmd_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .Clk(clk), .Reset(rst), .FrameActive(frame_active), .ByteStrobe(byte_strobe),
        .ByteData(byte_data), .RegWe(RegWe), .RegAddr(RegAddr), .RegData(RegData),
        .MemWe(MemWe), .MemAddr(MemAddr), .MemData(MemData), .MemReady(mem_ready),
        .Busy(Busy), .ErrCmd(ErrCmd), .Overrun(Overrun)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        is_reg;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    typedef struct packed {
        logic [95:0]   bytes;
        logic [3:0]    nbytes;
        logic          toggle;
        logic [2:0]    nexp;
        ev_t [3:0]     evs;
        logic          err;
    } vec_t;

    localparam ev_t NOEV = '0;
    localparam int NVEC = 7;

    vec_t vecs [NVEC];
    ev_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic ev_t ev(input logic r, input logic [15:0] a, input logic [7:0] d);
        ev_t e;
        e.is_reg = r;
        e.addr   = a;
        e.data   = d;
        return e;
    endfunction

    function automatic vec_t mkvec(input logic [95:0] b, input int n, input logic tog,
                                   input logic err, input int ne,
                                   input ev_t e0, input ev_t e1, input ev_t e2, input ev_t e3);
        vec_t v;
        v.bytes  = b << (8 * (12 - n));
        v.nbytes = 4'(n);
        v.toggle = tog;
        v.err    = err;
        v.nexp   = 3'(ne);
        v.evs[0] = e0;
        v.evs[1] = e1;
        v.evs[2] = e2;
        v.evs[3] = e3;
        return v;
    endfunction

    task automatic observe(input string kind, input ev_t act);
        ev_t e;
        $display("txn %s addr=0x%04h data=0x%02h", kind, act.addr, act.data);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got addr=0x%04h data=0x%02h, expected no write",
                     kind, act.addr, act.data);
        end else begin
            e = exp_q.pop_front();
            check({"event_", kind}, 32'(act), 32'(e));
        end
    endtask

    // Write monitor: scoreboard pops, plus hold checks on stalled memory writes.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_addr;
        logic [7:0]  prev_data;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_we", 32'(MemWe), 32'd1);
                    check("stall_hold_addr", 32'(MemAddr), 32'(prev_addr));
                    check("stall_hold_data", 32'(MemData), 32'(prev_data));
                end
                if (RegWe) observe("reg", ev(1'b1, {8'h00, RegAddr}, RegData));
                if (MemWe && mem_ready) observe("mem", ev(1'b0, MemAddr, MemData));
                prev_stall = MemWe && !mem_ready;
                prev_addr  = MemAddr;
                prev_data  = MemData;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (toggle_en) tog_bit = ~tog_bit;
        else tog_bit = 1'b1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_data   = b;
        byte_strobe = 1'b1;
        wait_cycles(2);
        byte_strobe = 1'b0;
        wait_cycles(2);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (Busy && n < 300) begin
            wait_cycles(1);
            n++;
        end
        check({name, "_idle"}, 32'(Busy), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string name;
        name = $sformatf("vec%0d", idx);
        for (int k = 0; k < int'(v.nexp); k++) exp_q.push_back(v.evs[k]);
        toggle_en    = v.toggle;
        ready_val    = 1'b1;
        frame_active = 1'b1;
        wait_cycles(2);
        check({name, "_start_err"}, 32'(ErrCmd), 32'd0);
        check({name, "_start_ovr"}, 32'(Overrun), 32'd0);
        for (int k = 0; k < int'(v.nbytes); k++) send_byte(v.bytes[95 - 8 * k -: 8]);
        frame_active = 1'b0;
        wait_cycles(2);
        wait_idle(name);
        toggle_en = 1'b0;
        wait_cycles(2);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_err"}, 32'(ErrCmd), 32'(v.err));
        check({name, "_ovr"}, 32'(Overrun), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = mkvec(96'h0110A5, 3, 1'b0, 1'b0, 1, ev(1, 16'h0010, 8'hA5), NOEV, NOEV, NOEV);
        vecs[1] = mkvec(96'h021234112233, 6, 1'b0, 1'b0, 3, ev(0, 16'h1234, 8'h11),
                        ev(0, 16'h1235, 8'h22), ev(0, 16'h1236, 8'h33), NOEV);
        vecs[2] = mkvec(96'h02FFFFAABB, 5, 1'b0, 1'b0, 2, ev(0, 16'hFFFF, 8'hAA),
                        ev(0, 16'h0000, 8'hBB), NOEV, NOEV);
        vecs[3] = mkvec(96'h5A0110A5, 4, 1'b0, 1'b1, 0, NOEV, NOEV, NOEV, NOEV);
        vecs[4] = mkvec(96'h0110A501205B, 6, 1'b0, 1'b0, 2, ev(1, 16'h0010, 8'hA5),
                        ev(1, 16'h0020, 8'h5B), NOEV, NOEV);
`ifdef FILL_CMD_EN
        vecs[5] = mkvec(96'h03001000047E, 6, 1'b1, 1'b0, 4, ev(0, 16'h0010, 8'h7E),
                        ev(0, 16'h0011, 8'h7E), ev(0, 16'h0012, 8'h7E), ev(0, 16'h0013, 8'h7E));
        vecs[6] = mkvec(96'h030020000055013344, 9, 1'b0, 1'b0, 1, ev(1, 16'h0033, 8'h44),
                        NOEV, NOEV, NOEV);
`else
        vecs[5] = mkvec(96'h03001000047E, 6, 1'b1, 1'b1, 0, NOEV, NOEV, NOEV, NOEV);
        vecs[6] = mkvec(96'h030020000055013344, 9, 1'b0, 1'b1, 0, NOEV, NOEV, NOEV, NOEV);
`endif

        rst          = 1'b1;
        frame_active = 1'b0;
        byte_strobe  = 1'b0;
        byte_data    = 8'h00;
        wait_cycles(3);
        check("rst_regwe", 32'(RegWe), 32'd0);
        check("rst_regaddr_data", 32'({RegAddr, RegData}), 32'd0);
        check("rst_memwe", 32'(MemWe), 32'd0);
        check("rst_memaddr_data", 32'({MemAddr, MemData}), 32'd0);
        check("rst_flags", 32'({Busy, ErrCmd, Overrun}), 32'd0);
        rst = 1'b0;
        wait_cycles(2);

        // Bytes outside a frame must be ignored.
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'hA5);
        check("outside_frame_err", 32'(ErrCmd), 32'd0);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // RegWe rises one cycle after the final byte and lasts a single cycle.
        exp_q.push_back(ev(1, 16'h0044, 8'h99));
        frame_active = 1'b1;
        wait_cycles(2);
        send_byte(8'h01);
        send_byte(8'h44);
        byte_data   = 8'h99;
        byte_strobe = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("latency_regwe", 32'(RegWe), 32'd1);
        check("latency_regaddr", 32'(RegAddr), 32'h44);
        @(negedge clk);
        check("pulse_width_regwe", 32'(RegWe), 32'd0);
        wait_cycles(1);
        byte_strobe  = 1'b0;
        frame_active = 1'b0;
        wait_cycles(3);
        check("latency_pending", 32'(exp_q.size()), 32'd0);

        // Backpressure: first write held, second byte dropped.
        ready_val = 1'b0;
        exp_q.push_back(ev(0, 16'h0040, 8'h11));
        frame_active = 1'b1;
        wait_cycles(2);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h11);
        send_byte(8'h22);
        check("ovr_flag", 32'(Overrun), 32'd1);
        check("ovr_memwe", 32'(MemWe), 32'd1);
        check("ovr_held", 32'({MemAddr, MemData}), 32'h004011);
        check("ovr_busy", 32'(Busy), 32'd1);
        frame_active = 1'b0;
        wait_cycles(3);
        check("ovr_after_end_memwe", 32'(MemWe), 32'd1);
        ready_val = 1'b1;
        wait_idle("ovr");
        check("ovr_pending", 32'(exp_q.size()), 32'd0);
        check("ovr_sticky", 32'(Overrun), 32'd1);
        frame_active = 1'b1;
        wait_cycles(2);
        check("ovr_cleared", 32'(Overrun), 32'd0);
        frame_active = 1'b0;
        wait_cycles(2);

        // Asynchronous reset while a stream write is stalled.
        ready_val    = 1'b0;
        frame_active = 1'b1;
        wait_cycles(2);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h50);
        send_byte(8'h77);
        check("pre_rst_memwe", 32'(MemWe), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_memwe", 32'(MemWe), 32'd0);
        check("async_rst_mem", 32'({MemAddr, MemData}), 32'd0);
        check("async_rst_reg", 32'({RegWe, RegAddr, RegData}), 32'd0);
        check("async_rst_flags", 32'({Busy, ErrCmd, Overrun}), 32'd0);
        frame_active = 1'b0;
        ready_val    = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(4);
        check("post_rst_pending", 32'(exp_q.size()), 32'd0);
        check("post_rst_memwe", 32'(MemWe), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
